// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: datapath width, NOP encoding and FSM state codes.
package instruction_fetch_pkg;

  localparam int CORE_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_obuf.sv
// Enable-gated output register with a configurable asynchronous reset value.
module instruction_fetch_obuf #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding word request at a time, with PC
// redirects applied immediately when idle or deferred until the in-flight ack.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic            stall_fetch
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_target;
  logic            pend_valid;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] fetch_target;
  logic [XLEN-1:0] next_pc;
  logic            accept;

  assign jump_target = {jump_addr[XLEN-1:2], 2'b00};
  assign accept      = (state == REQ) && imem_ack;

  // A redirect arriving in the ack cycle itself is the most recent one, so it wins.
  always_comb begin
    fetch_target = jump_taken ? jump_target : pc;
    if (jump_taken) begin
      next_pc = jump_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_VECTOR;
      stall_fetch <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (state == IDLE) begin
      if (phase_fetch) begin
        state       <= REQ;
        imem_req    <= 1'b1;
        imem_addr   <= fetch_target;
        stall_fetch <= 1'b1;
        pc          <= fetch_target;
      end else if (jump_taken) begin
        pc <= jump_target;
      end
    end else begin
      if (imem_ack) begin
        state       <= IDLE;
        imem_req    <= 1'b0;
        stall_fetch <= 1'b0;
        pc          <= next_pc;
        pend_valid  <= 1'b0;
      end else if (jump_taken) begin
        pend_valid  <= 1'b1;
        pend_target <= jump_target;
      end
    end
  end

  instruction_fetch_obuf #(
    .W(32),
    .RESET_VAL(NOP_INST)
  ) u_inst_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .d    (imem_rdata),
    .q    (inst)
  );

  instruction_fetch_obuf #(
    .W(XLEN),
    .RESET_VAL('0)
  ) u_pc_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .d    (imem_addr),
    .q    (curr_pc_fd)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        phase_fetch;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic        stall_fetch;

  logic        w2_imem_req;
  logic [31:0] w2_imem_addr;
  logic [31:0] w2_inst;
  logic [31:0] w2_curr_pc_fd;
  logic        w2_stall_fetch;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Reference model state, described in terms of fetch transactions.
  logic        m_busy;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_inst;
  logic [31:0] m_cpc;
  logic        m_redirect_waiting;
  logic [31:0] m_redirect_to;

  instruction_fetch #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_fetch(phase_fetch),
    .jump_taken (jump_taken),
    .jump_addr  (jump_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .inst       (inst),
    .curr_pc_fd (curr_pc_fd),
    .stall_fetch(stall_fetch)
  );

  instruction_fetch #(
    .XLEN(32),
    .RESET_VECTOR(32'hFFFF_FFFC)
  ) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_fetch(phase_fetch),
    .jump_taken (jump_taken),
    .jump_addr  (jump_addr),
    .imem_req   (w2_imem_req),
    .imem_addr  (w2_imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .inst       (w2_inst),
    .curr_pc_fd (w2_curr_pc_fd),
    .stall_fetch(w2_stall_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy             = 1'b0;
    m_pc               = 32'h0;
    m_addr             = 32'h0;
    m_inst             = 32'h0000_0013;
    m_cpc              = 32'h0;
    m_redirect_waiting = 1'b0;
    m_redirect_to      = 32'h0;
  endtask

  // One clock edge of fetch-stage behaviour, expressed as transaction rules.
  task automatic model_clock(input logic ph, input logic jt, input logic [31:0] ja,
                             input logic ak, input logic [31:0] rd);
    logic [31:0] tgt;
    tgt = ja & 32'hFFFF_FFFC;
    if (!m_busy) begin
      if (jt) m_pc = tgt;
      if (ph) begin
        m_busy = 1'b1;
        m_addr = m_pc;
      end
    end else if (ak) begin
      m_inst = rd;
      m_cpc  = m_addr;
      m_busy = 1'b0;
      if (jt) m_pc = tgt;
      else if (m_redirect_waiting) m_pc = m_redirect_to;
      else m_pc = m_addr + 32'd4;
      m_redirect_waiting = 1'b0;
    end else if (jt) begin
      m_redirect_waiting = 1'b1;
      m_redirect_to      = tgt;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      check("stall_fetch", {31'b0, stall_fetch}, {31'b0, m_busy});
      if (m_busy) check("imem_addr", imem_addr, m_addr);
      check("inst", inst, m_inst);
      check("curr_pc_fd", curr_pc_fd, m_cpc);
    end
  end

  task automatic step(input logic ph, input logic jt, input logic [31:0] ja,
                      input logic ak, input logic [31:0] rd);
    phase_fetch = ph;
    jump_taken  = jt;
    jump_addr   = ja;
    imem_ack    = ak;
    imem_rdata  = rd;
    @(posedge clk);
    model_clock(ph, jt, ja, ak, rd);
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    phase_fetch = 1'b0;
    jump_taken  = 1'b0;
    imem_ack    = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int stall_cnt;
    jump_addr  = 32'h0;
    imem_rdata = 32'h0;
    #2;
    apply_reset();
    chk_en = 1'b1;

    check("rst imem_req", {31'b0, imem_req}, 32'h0);
    check("rst stall", {31'b0, stall_fetch}, 32'h0);
    check("rst inst", inst, 32'h0000_0013);
    check("rst curr_pc_fd", curr_pc_fd, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);

    // Single fetch with three wait cycles; the wrap instance fetches alongside.
    stall_cnt = 0;
    step(1, 0, 0, 0, 0);
    if (stall_fetch) stall_cnt++;
    check("wait addr", imem_addr, 32'h0);
    check("wrap first addr", w2_imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      if (stall_fetch) stall_cnt++;
      check("wait addr held", imem_addr, 32'h0);
    end
    step(0, 0, 0, 1, 32'h0010_0093);
    if (stall_fetch) stall_cnt++;
    check("stall cycles", stall_cnt, 32'd4);
    check("wait inst", inst, 32'h0010_0093);
    check("wait curr_pc_fd", curr_pc_fd, 32'h0);
    step(1, 0, 0, 0, 0);
    check("pc after fetch", imem_addr, 32'h4);
    check("wrap next addr", w2_imem_addr, 32'h0);
    step(0, 0, 0, 1, 32'h1111_1111);

    // Five back-to-back zero-wait fetches.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
      check("b2b addr", imem_addr, 32'(4 * i));
      step(0, 0, 0, 1, 32'hA000_0000 + 32'(i));
      check("b2b curr_pc_fd", curr_pc_fd, 32'(4 * i));
      check("b2b inst", inst, 32'hA000_0000 + 32'(i));
    end

    // Redirect while a fetch from 8 is in flight.
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h0);
    end
    step(1, 0, 0, 0, 0);
    check("mid pc", imem_addr, 32'h8);
    step(0, 1, 32'h200, 0, 0);
    step(0, 0, 0, 1, 32'hCAFE_0008);
    check("mid curr_pc_fd", curr_pc_fd, 32'h8);
    check("mid inst", inst, 32'hCAFE_0008);
    step(1, 0, 0, 0, 0);
    check("mid redirect addr", imem_addr, 32'h200);
    step(0, 0, 0, 1, 32'h0);

    // Redirect and fetch together in IDLE: target wins, low bits dropped.
    step(1, 1, 32'h0000_0103, 0, 0);
    check("idle jump addr", imem_addr, 32'h100);
    step(0, 0, 0, 1, 32'h0);

    // Reset during an outstanding fetch followed by a stray ack.
    step(1, 0, 0, 0, 0);
    apply_reset();
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    check("late ack inst", inst, 32'h0000_0013);
    check("late ack req", {31'b0, imem_req}, 32'h0);
    check("late ack stall", {31'b0, stall_fetch}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) < 3), $urandom,
             ($urandom_range(0, 9) < 4), $urandom);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
